// File: rtl/aq_mp_clk_div_top.sv
// Multi-channel programmable clock-enable / gated-clock generator with a req/ack ratio update
// that is applied only at a divider boundary. Also registers the AXI master clock enable.
module aq_mp_clk_div_top #(
  parameter int unsigned CH_NUM    = 2,
  parameter int unsigned DIV_W     = 4,
  parameter int unsigned RST_RATIO = 1
) (
  input  logic                    forever_cpuclk,
  input  logic                    clkgen_rst_b,
  input  logic                    pad_yy_scan_mode,
  input  logic [CH_NUM-1:0]       div_cfg_vld,
  input  logic [CH_NUM*DIV_W-1:0] div_cfg_ratio,
  output logic [CH_NUM-1:0]       div_cfg_ack,
  output logic [CH_NUM*DIV_W-1:0] div_ratio_cur,
  output logic [CH_NUM-1:0]       clk_en,
  output logic [CH_NUM-1:0]       clk_out,
  input  logic                    axim_clk_en,
  output logic                    axim_clk_en_f
);

  typedef enum logic [0:0] {StIdle, StPend} div_state_e;

  localparam logic [DIV_W-1:0] RstRatio = DIV_W'(RST_RATIO);

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    div_state_e       state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] ratio_cur_q, ratio_cur_d;
    logic [DIV_W-1:0] ratio_nxt_q, ratio_nxt_d;
    logic             en_f_q;
    logic             ack_q, ack_d;
    logic             gate_q;
    logic             boundary;

    assign boundary = (cnt_q == ratio_cur_q);

    always_comb begin
      state_d     = state_q;
      cnt_d       = boundary ? '0 : cnt_q + DIV_W'(1);
      ratio_cur_d = ratio_cur_q;
      ratio_nxt_d = ratio_nxt_q;
      ack_d       = 1'b0;
      case (state_q)
        StIdle: begin
          if (div_cfg_vld[i]) begin
            ratio_nxt_d = div_cfg_ratio[i*DIV_W +: DIV_W];
            state_d     = StPend;
          end
        end
        StPend: begin
          // Apply only on a boundary so the enable period in flight is never cut short.
          if (boundary) begin
            ratio_cur_d = ratio_nxt_q;
            cnt_d       = '0;
            ack_d       = 1'b1;
            state_d     = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    always_ff @(posedge forever_cpuclk or negedge clkgen_rst_b) begin
      if (!clkgen_rst_b) begin
        state_q     <= StIdle;
        cnt_q       <= '0;
        ratio_cur_q <= RstRatio;
        ratio_nxt_q <= '0;
        en_f_q      <= 1'b0;
        ack_q       <= 1'b0;
      end else begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        ratio_cur_q <= ratio_cur_d;
        ratio_nxt_q <= ratio_nxt_d;
        en_f_q      <= boundary;
        ack_q       <= ack_d;
      end
    end

    // Gate enable sampled while the clock is low, so clk_out cannot glitch.
    always_ff @(negedge forever_cpuclk or negedge clkgen_rst_b) begin
      if (!clkgen_rst_b) begin
        gate_q <= 1'b0;
      end else begin
        gate_q <= en_f_q;
      end
    end

    assign clk_en[i]                         = pad_yy_scan_mode | en_f_q;
    assign clk_out[i]                        = forever_cpuclk & gate_q;
    assign div_cfg_ack[i]                    = ack_q;
    assign div_ratio_cur[i*DIV_W +: DIV_W]   = ratio_cur_q;
  end

  always_ff @(posedge forever_cpuclk or negedge clkgen_rst_b) begin
    if (!clkgen_rst_b) begin
      axim_clk_en_f <= 1'b0;
    end else begin
      axim_clk_en_f <= axim_clk_en;
    end
  end

endmodule

// File: tb/tb_aq_mp_clk_div_top.sv
// Randomized scoreboard bench for aq_mp_clk_div_top; expected outputs come from a modular-arithmetic
// schedule model (enable after edge n iff (n - origin) is a multiple of ratio+1).
module tb_aq_mp_clk_div_top;
  localparam int CH = 2;
  localparam int W  = 4;

  logic            forever_cpuclk;
  logic            clkgen_rst_b;
  logic            pad_yy_scan_mode;
  logic [CH-1:0]   div_cfg_vld;
  logic [CH*W-1:0] div_cfg_ratio;
  logic [CH-1:0]   div_cfg_ack;
  logic [CH*W-1:0] div_ratio_cur;
  logic [CH-1:0]   clk_en;
  logic [CH-1:0]   clk_out;
  logic            axim_clk_en;
  logic            axim_clk_en_f;

  aq_mp_clk_div_top #(.CH_NUM(CH), .DIV_W(W), .RST_RATIO(1)) dut (
    .forever_cpuclk  (forever_cpuclk),
    .clkgen_rst_b    (clkgen_rst_b),
    .pad_yy_scan_mode(pad_yy_scan_mode),
    .div_cfg_vld     (div_cfg_vld),
    .div_cfg_ratio   (div_cfg_ratio),
    .div_cfg_ack     (div_cfg_ack),
    .div_ratio_cur   (div_ratio_cur),
    .clk_en          (clk_en),
    .clk_out         (clk_out),
    .axim_clk_en     (axim_clk_en),
    .axim_clk_en_f   (axim_clk_en_f)
  );

  initial forever_cpuclk = 1'b0;
  always #5 forever_cpuclk = ~forever_cpuclk;

  typedef struct {
    logic [CH-1:0]   clk_en;
    logic [CH-1:0]   ack;
    logic [CH*W-1:0] ratio;
    logic [CH-1:0]   clk_out;
    logic            axim;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int   n;
  int   e0[CH];
  int   r[CH];
  int   nxt[CH];
  bit   pend[CH];
  bit   prev_en[CH];

  // Requester state
  bit       req[CH];
  int       req_ratio[CH];
  bit       rand_mode = 0;
  bit       scan_sel  = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0;
    for (int c = 0; c < CH; c++) begin
      e0[c] = 0; r[c] = 1; nxt[c] = 0; pend[c] = 0; prev_en[c] = 0; req[c] = 0;
    end
  endtask

  task automatic model_step(input logic [CH-1:0] vld, input logic [CH*W-1:0] rat,
                            input bit scan, input bit axim, output logic [CH-1:0] ack);
    exp_t e;
    logic [CH-1:0] en;
    n++;
    for (int c = 0; c < CH; c++) begin
      bit bnd;
      bnd    = ((n - e0[c]) % (r[c] + 1)) == 0;
      ack[c] = 1'b0;
      if (pend[c] && bnd) begin
        r[c] = nxt[c]; e0[c] = n; pend[c] = 0; ack[c] = 1'b1;
      end else if (!pend[c] && vld[c]) begin
        pend[c] = 1; nxt[c] = int'(rat[c*W +: W]);
      end
      e.clk_out[c]     = prev_en[c];
      prev_en[c]       = bnd;
      en[c]            = bnd;
      e.ratio[c*W +: W] = W'(r[c]);
    end
    e.ack    = ack;
    e.clk_en = scan ? {CH{1'b1}} : en;
    e.axim   = axim;
    q.push_back(e);
  endtask

  task automatic run(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      logic [CH-1:0]   vld;
      logic [CH*W-1:0] rat;
      logic [CH-1:0]   ack;
      bit              scan;
      bit              axim;
      @(negedge forever_cpuclk);
      for (int c = 0; c < CH; c++) begin
        if (rand_mode && !req[c] && $urandom_range(7) == 0) begin
          req[c] = 1; req_ratio[c] = $urandom_range(15);
        end
        vld[c] = req[c];
        // While pending the ratio field must be ignored, so drive noise there.
        rat[c*W +: W] = pend[c] ? W'($urandom) : W'(req_ratio[c]);
      end
      scan = rand_mode ? ($urandom_range(9) == 0) : scan_sel;
      axim = 1'($urandom);
      div_cfg_vld      = vld;
      div_cfg_ratio    = rat;
      pad_yy_scan_mode = scan;
      axim_clk_en      = axim;
      model_step(vld, rat, scan, axim, ack);
      for (int c = 0; c < CH; c++) begin
        if (ack[c]) begin
          if (rand_mode && $urandom_range(3) == 0) req_ratio[c] = $urandom_range(15);
          else req[c] = 0;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge forever_cpuclk);
    clkgen_rst_b     = 1'b0;
    pad_yy_scan_mode = 1'b0;
    div_cfg_vld      = '0;
    model_reset();
    repeat (2) @(posedge forever_cpuclk);
    #2;
    clkgen_rst_b = 1'b1;
  endtask

  // Monitor: outputs are presented every cycle, sampled 1 time unit after the edge.
  initial begin
    forever begin
      @(posedge forever_cpuclk);
      #1;
      if (!clkgen_rst_b) begin
        chk("rst_clk_en", clk_en, 0);
        chk("rst_ack", div_cfg_ack, 0);
        chk("rst_ratio", div_ratio_cur, {W'(1), W'(1)});
        chk("rst_clk_out", clk_out, 0);
        chk("rst_axim_f", axim_clk_en_f, 0);
      end else if (q.size() == 0) begin
        chk("queue_empty", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("clk_en", clk_en, e.clk_en);
        chk("ack", div_cfg_ack, e.ack);
        chk("ratio_cur", div_ratio_cur, e.ratio);
        chk("clk_out", clk_out, e.clk_out);
        chk("axim_clk_en_f", axim_clk_en_f, e.axim);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    clkgen_rst_b     = 1'b0;
    pad_yy_scan_mode = 1'b0;
    div_cfg_vld      = '0;
    div_cfg_ratio    = '0;
    axim_clk_en      = 1'b0;
    for (int c = 0; c < CH; c++) req_ratio[c] = 0;
    model_reset();
    do_reset();

    run(8);                                      // legacy divide-by-2 after reset
    req[0] = 1; req_ratio[0] = 3;   run(20);     // ch0 -> ratio 3
    req[1] = 1; req_ratio[1] = 0;   run(8);      // ch1 -> ratio 0
    req[1] = 1; req_ratio[1] = 2;   run(10);     // ch1 -> ratio 2
    scan_sel = 1; run(12);
    scan_sel = 0; run(8);
    req[0] = 1; req_ratio[0] = 5;
    req[1] = 1; req_ratio[1] = 2;   run(30);     // simultaneous requests
    req[0] = 1; req_ratio[0] = 7;   run(1);      // captured, now pending
    do_reset();                                  // pending request dropped
    run(10);

    rand_mode = 1;
    run(2000);
    rand_mode = 0;
    do_reset();
    run(6);

    @(posedge forever_cpuclk);
    #3;
    chk("drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
